// File: rtl/fir_tap_bank.sv
// fir_tap_bank: sample delay line with a shadow copy that is read out one
// tap per cycle after a load strobe. Samples pass through bit-exact.
module fir_tap_bank #(
   parameter int BITS_X = 16,
   parameter int TAPS   = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     STM,
   input  logic                     LDX,
   input  logic [BITS_X-1:0]        DATTA,
   output logic [BITS_X-1:0]        tap_out,
   output logic [$clog2(TAPS)-1:0]  tap_idx,
   output logic                     tap_valid,
   output logic                     busy,
   output logic                     done,
   output logic                     overrun
);

   localparam int IW = $clog2(TAPS);
   localparam logic [IW-1:0] LAST_IDX = IW'(TAPS - 1);

   typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

   state_t            state;
   logic [IW-1:0]     cnt;
   logic [BITS_X-1:0] stage  [TAPS];
   logic [BITS_X-1:0] shadow [TAPS];
   logic              load;

   // A load is only accepted from IDLE; a strobe during READ is flagged instead.
   assign load = (state == IDLE) && LDX;

   // Delay line: shifts on every strobe regardless of readout state.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < TAPS; i++) stage[i] <= '0;
      end else if (STM) begin
         stage[0] <= DATTA;
         for (int i = 1; i < TAPS; i++) stage[i] <= stage[i-1];
      end
   end

   // Shadow bank: snapshots the pre-shift delay line when a load is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < TAPS; i++) shadow[i] <= '0;
      end else if (load) begin
         for (int i = 0; i < TAPS; i++) shadow[i] <= stage[i];
      end
   end

   // Readout FSM: index counter, state and sticky overrun flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         overrun <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (LDX) state <= READ;
            end
            READ: begin
               if (LDX) overrun <= 1'b1;
               if (cnt == LAST_IDX) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Counter rests at zero in IDLE, so the output mux needs no state gating.
   assign tap_valid = (state == READ);
   assign busy      = tap_valid;
   assign tap_idx   = cnt;
   assign tap_out   = shadow[cnt];
   assign done      = (state == READ) && (cnt == LAST_IDX);

endmodule

// File: tb/tb_fir_tap_bank.sv
// Directed bench for fir_tap_bank with TAPS=4: a per-cycle vector table
// plus short hand-written corner-case sequences.
module tb_fir_tap_bank;

   localparam int BX = 16;
   localparam int TP = 4;

   logic          clk = 1'b0;
   logic          rst, stm, ldx;
   logic [BX-1:0] datta;
   logic [BX-1:0] tap_out;
   logic [1:0]    tap_idx;
   logic          tap_valid, busy, done, overrun;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic          r, s, l;
      logic [BX-1:0] d;
      logic          v;
      logic [1:0]    idx;
      logic [BX-1:0] out;
      logic          dn, ov;
   } vec_t;

   vec_t tbl[$];

   fir_tap_bank #(.BITS_X(BX), .TAPS(TP)) dut (
      .clk(clk), .rst(rst), .STM(stm), .LDX(ldx), .DATTA(datta),
      .tap_out(tap_out), .tap_idx(tap_idx), .tap_valid(tap_valid),
      .busy(busy), .done(done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic add(input logic r, s, l, input logic [BX-1:0] d,
                      input logic v, input logic [1:0] idx,
                      input logic [BX-1:0] out, input logic dn, ov);
      vec_t e;
      e.r = r; e.s = s; e.l = l; e.d = d;
      e.v = v; e.idx = idx; e.out = out; e.dn = dn; e.ov = ov;
      tbl.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [BX-1:0] got, exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
   endtask

   task automatic step(input logic r, s, l, input logic [BX-1:0] d);
      @(negedge clk);
      rst = r; stm = s; ldx = l; datta = d;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic v, input logic [1:0] idx,
                          input logic [BX-1:0] out, input logic dn, ov);
      chk({tag, ".tap_valid"}, BX'(tap_valid), BX'(v));
      chk({tag, ".busy"},      BX'(busy),      BX'(v));
      chk({tag, ".tap_idx"},   BX'(tap_idx),   BX'(idx));
      chk({tag, ".tap_out"},   tap_out,        out);
      chk({tag, ".done"},      BX'(done),      BX'(dn));
      chk({tag, ".overrun"},   BX'(overrun),   BX'(ov));
   endtask

   initial begin
      rst = 1'b1; stm = 1'b0; ldx = 1'b0; datta = '0;

      // reset, then readout of an all-zero delay line
      add(1,0,0,0,   0,0,0,0,0);
      add(0,0,1,0,   1,0,0,0,0);
      add(0,0,0,0,   1,1,0,0,0);
      add(0,0,0,0,   1,2,0,0,0);
      add(0,0,0,0,   1,3,0,1,0);
      add(0,0,0,0,   0,0,0,0,0);
      // shift in 1..4, readout newest first
      add(0,1,0,1,   0,0,0,0,0);
      add(0,1,0,2,   0,0,0,0,0);
      add(0,1,0,3,   0,0,0,0,0);
      add(0,1,0,4,   0,0,0,0,0);
      add(0,0,1,0,   1,0,4,0,0);
      add(0,1,0,5,   1,1,3,0,0);
      add(0,0,0,0,   1,2,2,0,0);
      add(0,0,0,0,   1,3,1,1,0);
      add(0,0,0,0,   0,0,4,0,0);
      add(0,0,1,0,   1,0,5,0,0);
      add(0,0,0,0,   1,1,4,0,0);
      add(0,0,0,0,   1,2,3,0,0);
      add(0,0,0,0,   1,3,2,1,0);
      add(0,0,0,0,   0,0,5,0,0);
      // simultaneous shift and load from stage 4,3,2,1
      add(1,0,0,0,   0,0,0,0,0);
      add(0,1,0,1,   0,0,0,0,0);
      add(0,1,0,2,   0,0,0,0,0);
      add(0,1,0,3,   0,0,0,0,0);
      add(0,1,0,4,   0,0,0,0,0);
      add(0,1,1,9,   1,0,4,0,0);
      add(0,0,0,0,   1,1,3,0,0);
      add(0,0,0,0,   1,2,2,0,0);
      add(0,0,0,0,   1,3,1,1,0);
      add(0,0,0,0,   0,0,4,0,0);
      add(0,0,1,0,   1,0,9,0,0);
      add(0,0,0,0,   1,1,4,0,0);
      add(0,0,0,0,   1,2,3,0,0);
      add(0,0,0,0,   1,3,2,1,0);
      add(0,0,0,0,   0,0,9,0,0);
      // load strobe while idx 1 is shown: no restart, sticky overrun
      add(0,0,1,0,   1,0,9,0,0);
      add(0,0,0,0,   1,1,4,0,0);
      add(0,0,1,0,   1,2,3,0,1);
      add(0,0,0,0,   1,3,2,1,1);
      add(0,0,0,0,   0,0,9,0,1);
      // reset at idx 2 aborts readout and clears everything
      add(0,0,1,0,   1,0,9,0,1);
      add(0,0,0,0,   1,1,4,0,1);
      add(0,0,0,0,   1,2,3,0,1);
      add(1,0,0,0,   0,0,0,0,0);
      add(0,0,1,0,   1,0,0,0,0);
      add(0,0,0,0,   1,1,0,0,0);
      add(0,0,0,0,   1,2,0,0,0);
      add(0,0,0,0,   1,3,0,1,0);
      add(0,0,0,0,   0,0,0,0,0);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].r, tbl[i].s, tbl[i].l, tbl[i].d);
         chk_all($sformatf("vec%0d", i), tbl[i].v, tbl[i].idx, tbl[i].out,
                 tbl[i].dn, tbl[i].ov);
      end

      // load strobe in the done cycle is rejected; next cycle's load is accepted
      step(1,0,0,16'h0000);
      step(0,1,0,16'h0007);
      step(0,0,1,16'h0000);  chk_all("mp.idx0", 1,0,16'h0007,0,0);
      step(0,0,0,16'h0000);  chk_all("mp.idx1", 1,1,16'h0000,0,0);
      step(0,0,0,16'h0000);  chk_all("mp.idx2", 1,2,16'h0000,0,0);
      step(0,0,0,16'h0000);  chk_all("mp.idx3", 1,3,16'h0000,1,0);
      step(0,0,1,16'h0000);  chk_all("mp.rej",  0,0,16'h0007,0,1);
      step(0,0,1,16'h0000);  chk_all("mp.acc",  1,0,16'h0007,0,1);
      step(0,0,0,16'h0000);
      step(0,0,0,16'h0000);
      step(0,0,0,16'h0000);  chk_all("mp.end",  1,3,16'h0000,1,1);

      // bit-exact pass-through of extreme codes
      step(1,0,0,16'h0000);
      step(0,1,0,16'hFFFF);
      step(0,1,0,16'h8000);
      step(0,1,0,16'h7FFF);
      step(0,0,1,16'h0000);  chk_all("bx.idx0", 1,0,16'h7FFF,0,0);
      step(0,0,0,16'h0000);  chk_all("bx.idx1", 1,1,16'h8000,0,0);
      step(0,0,0,16'h0000);  chk_all("bx.idx2", 1,2,16'hFFFF,0,0);
      step(0,0,0,16'h0000);  chk_all("bx.idx3", 1,3,16'h0000,1,0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
